alu_ctrl_seq: RTL and testbench

- Parametrised successor to the 16-bit RISC ALU control decode: it decodes ALUOp and Function, and also executes the operation, with a valid/ready handshake on both input and output.
- Single-cycle ops (add/sub/logic/slt/shift) complete one cycle after acceptance. MUL runs as an iterative shift-add sequencer.
- Sits between the ID/EX register and the EX/MEM register. Stalls the pipeline through in_ready and out_valid.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_ctrl_dec.sv | 48 ++++
 rtl/alu_ctrl_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control/execute slice: ALU control codes,
// ALUOp and Function field values, and the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    localparam int unsigned FN_ADD = 0;
    localparam int unsigned FN_SUB = 1;
    localparam int unsigned FN_AND = 2;
    localparam int unsigned FN_OR  = 3;
    localparam int unsigned FN_SLT = 4;
    localparam int unsigned FN_MUL = 5;
    localparam int unsigned FN_SLL = 6;
    localparam int unsigned FN_SRL = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: (ALUOp, Function) -> control code,
// MUL flag and illegal flag. Shared with the single-cycle core.
module alu_ctrl_dec
    import alu_pkg::*;
#(
    parameter int unsigned FUNCT_W = 4,
    parameter int unsigned MUL_EN  = 1
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alucnt,
    output logic               is_mul,
    output logic               illegal
);

    always_comb begin
        alucnt  = ALU_AND;
        is_mul  = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD:  alucnt = ALU_ADD;
            OP_SUB:  alucnt = ALU_SUB;
            OP_SLT:  alucnt = ALU_SLT;
            default: begin
                case (funct)
                    FUNCT_W'(FN_ADD): alucnt = ALU_ADD;
                    FUNCT_W'(FN_SUB): alucnt = ALU_SUB;
                    FUNCT_W'(FN_AND): alucnt = ALU_AND;
                    FUNCT_W'(FN_OR):  alucnt = ALU_OR;
                    FUNCT_W'(FN_SLT): alucnt = ALU_SLT;
                    FUNCT_W'(FN_SLL): alucnt = ALU_SLL;
                    FUNCT_W'(FN_SRL): alucnt = ALU_SRL;
                    // Without a multiplier, MUL falls through to the illegal path
                    FUNCT_W'(FN_MUL): begin
                        if (MUL_EN != 0) begin
                            alucnt = ALU_MUL;
                            is_mul = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus execute with valid/ready on both sides. Single-cycle
// ops finish one cycle after accept; MUL runs as a WIDTH-step shift-add loop.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FUNCT_W = 4,
    parameter int unsigned SHAMT_W = 4,
    parameter int unsigned MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         alucnt,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state, state_d;
    logic               ready_en;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   acc, acc_d;
    logic [WIDTH-1:0]   mcand, mcand_d;
    logic [WIDTH-1:0]   mplier, mplier_d;
    logic [WIDTH-1:0]   result_d;
    logic [2:0]         alucnt_d;
    logic               zero_d, ovf_d, illegal_d, out_valid_d;

    logic [2:0]         dec_alucnt;
    logic               dec_is_mul, dec_illegal;
    logic               accept_c;
    logic [WIDTH-1:0]   sum_c, diff_c, op_res_c, step_acc_c;
    logic               op_ovf_c, slt_c;
    logic [SHAMT_W-1:0] shamt_c;

    alu_ctrl_dec #(
        .FUNCT_W (FUNCT_W),
        .MUL_EN  (MUL_EN)
    ) u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .alucnt  (dec_alucnt),
        .is_mul  (dec_is_mul),
        .illegal (dec_illegal)
    );

    // ready_en keeps in_ready low while reset is held and for the release edge
    assign in_ready = ready_en && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
    assign accept_c = in_valid && in_ready;

    // Single-cycle datapath on the presented operands
    always_comb begin
        sum_c    = a + b;
        diff_c   = a - b;
        shamt_c  = b[SHAMT_W-1:0];
        slt_c    = $signed(a) < $signed(b);
        op_res_c = '0;
        op_ovf_c = 1'b0;
        case (dec_alucnt)
            ALU_ADD: begin
                op_res_c = sum_c;
                op_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                op_res_c = diff_c;
                op_ovf_c = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: op_res_c = a & b;
            ALU_OR:  op_res_c = a | b;
            ALU_SLT: op_res_c = {{(WIDTH-1){1'b0}}, slt_c};
            ALU_SLL: op_res_c = a << shamt_c;
            ALU_SRL: op_res_c = a >> shamt_c;
            default: op_res_c = '0;
        endcase
        // Illegal decodes share ALU_AND's code, so force the result here
        if (dec_illegal) begin
            op_res_c = '0;
            op_ovf_c = 1'b0;
        end
    end

    assign step_acc_c = mplier[0] ? (acc + mcand) : acc;

    // Next-state and output-register logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_d       = acc;
        mcand_d     = mcand;
        mplier_d    = mplier;
        result_d    = result;
        alucnt_d    = alucnt;
        zero_d      = zero;
        ovf_d       = ovf;
        illegal_d   = illegal;
        out_valid_d = out_valid;

        case (state)
            ST_MUL: begin
                acc_d    = step_acc_c;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = step_acc_c;
                    alucnt_d    = ALU_MUL;
                    zero_d      = (step_acc_c == '0);
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE or in DONE with out_ready, so it overrides
        if (accept_c) begin
            if (dec_is_mul) begin
                state_d     = ST_MUL;
                out_valid_d = 1'b0;
                cnt_d       = '0;
                acc_d       = '0;
                mcand_d     = a;
                mplier_d    = b;
                alucnt_d    = ALU_MUL;
                ovf_d       = 1'b0;
                illegal_d   = 1'b0;
            end else begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                result_d    = op_res_c;
                alucnt_d    = dec_alucnt;
                zero_d      = (op_res_c == '0);
                ovf_d       = op_ovf_c;
                illegal_d   = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready_en  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            alucnt    <= ALU_AND;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            ready_en  <= 1'b1;
            cnt       <= cnt_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
            result    <= result_d;
            alucnt    <= alucnt_d;
            zero      <= zero_d;
            ovf       <= ovf_d;
            illegal   <= illegal_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed cases plus randomized traffic with random
// backpressure, scored against a transaction-level arithmetic model.
module tb_alu_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  alucnt;
    logic        zero;
    logic        ovf;
    logic        illegal;

    int unsigned n_tests;
    int unsigned n_fail;
    bit          acc_flag;
    logic [21:0] exp_q[$];

    alu_ctrl_seq #(
        .WIDTH   (16),
        .FUNCT_W (4),
        .SHAMT_W (4),
        .MUL_EN  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .alucnt    (alucnt),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {illegal, ovf, zero, alucnt[2:0], result[15:0]} from plain integer arithmetic
    function automatic logic [21:0] model(input logic [1:0] op, input logic [3:0] fn,
                                          input logic [15:0] x, input logic [15:0] y);
        int          k, sx, sy, full;
        int unsigned ux, uy, r;
        logic [2:0]  code;
        bit          ov, ill;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        r = 0; ov = 0; ill = 0; code = 3'b000;
        case (op)
            2'b10:   k = 0;
            2'b01:   k = 1;
            2'b11:   k = 4;
            default: k = (fn <= 4'd7) ? int'(fn) : -1;
        endcase
        case (k)
            0: begin code = 3'b010; full = sx + sy; r = (ux + uy) % 65536;
                     ov = (full > 32767) || (full < -32768); end
            1: begin code = 3'b110; full = sx - sy; r = (ux + 65536 - uy) % 65536;
                     ov = (full > 32767) || (full < -32768); end
            2: begin code = 3'b000; r = ux & uy; end
            3: begin code = 3'b001; r = ux | uy; end
            4: begin code = 3'b111; r = (sx < sy) ? 1 : 0; end
            5: begin code = 3'b011; r = (ux * uy) % 65536; end
            6: begin code = 3'b100; r = (ux << (uy % 16)) % 65536; end
            7: begin code = 3'b101; r = ux >> (uy % 16); end
            default: begin ill = 1; code = 3'b000; r = 0; end
        endcase
        return {ill, ov, (r == 0), code, 16'(r)};
    endfunction

    // Called at a negedge with inputs already set; scores both handshakes, returns at next negedge
    task automatic tick();
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("spurious_out", 32'(out_valid), 32'd0);
            else
                check("txn", {10'b0, illegal, ovf, zero, alucnt, result}, {10'b0, exp_q.pop_front()});
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) exp_q.push_back(model(alu_op, funct, a, b));
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] fn,
                        input logic [15:0] x, input logic [15:0] y);
        alu_op = op; funct = fn; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_flag) break;
        end
        check("accept_timeout", 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, sent, seen;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct = 4'h0; a = '0; b = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {10'b0, illegal, ovf, zero, alucnt, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // ADD overflow, one cycle latency
        out_ready = 1'b1;
        send(2'b10, 4'h0, 16'h7FFF, 16'h0001);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(result), 32'h8000);
        check("add_flags", {28'b0, alucnt, ovf}, {28'b0, 3'b010, 1'b1});
        check("add_zero", 32'(zero), 32'd0);
        tick();

        send(2'b00, 4'h1, 16'h1234, 16'h1234);
        check("sub_res", {13'b0, result, alucnt, zero, ovf}, {13'b0, 16'h0000, 3'b110, 1'b1, 1'b0});
        tick();

        send(2'b11, 4'h0, 16'hFFFF, 16'h0000);
        check("slt_res", 32'(result), 32'd1);
        tick();

        // MUL: in_ready low for WIDTH cycles, result on the next
        send(2'b00, 4'h5, 16'd300, 16'd300);
        n = 0; bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            tick();
            n++;
        end
        check("mul_latency", 32'(n), 32'd16);
        check("mul_busy_ready", 32'(bad), 32'd0);
        check("mul_result", 32'(result), 32'h5F90);
        tick();

        // Backpressure then back-to-back
        out_ready = 1'b0;
        send(2'b10, 4'h0, 16'h0001, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {15'b0, out_valid, result}, {15'b0, 1'b1, 16'h0003});
            check("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(2'b00, 4'h3, 16'h00F0, 16'h0F00);
        check("b2b_or", {13'b0, result, alucnt}, {13'b0, 16'h0FF0, 3'b001});
        tick();

        send(2'b00, 4'hA, 16'h1234, 16'h5678);
        check("illegal", {11'b0, illegal, zero, alucnt, result}, {11'b0, 1'b1, 1'b1, 3'b000, 16'h0000});
        tick();

        send(2'b00, 4'h6, 16'h0001, 16'h000F);
        check("sll_res", {13'b0, result, alucnt}, {13'b0, 16'h8000, 3'b100});
        tick();

        // Reset in the middle of a MUL drops the pending result
        send(2'b00, 4'h5, 16'hFFFF, 16'hFFFF);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);

        // Randomized traffic with random stalls on both sides
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 300; cyc++) begin
            if (!in_valid && ($urandom % 4 != 0)) begin
                alu_op = 2'($urandom_range(0, 3));
                if ($urandom % 4 == 0) funct = 4'($urandom_range(8, 15));
                else                   funct = 4'($urandom_range(0, 7));
                a = pick_operand();
                b = pick_operand();
                in_valid = 1'b1;
            end
            out_ready = ($urandom % 10) < 7;
            tick();
            if (acc_flag) begin
                in_valid = 1'b0;
                sent++;
            end
        end
        check("rand_sent", 32'(sent), 32'd300);

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
